// File: rtl/spi_link_pkg.sv
// Shared definitions for the inter-board SPI transmit link.
//   - state_t     : transmitter FSM states
//   - DEF_DATA_W  : default payload width
//   - DEF_CLK_DIV : default CLK cycles per SCLK half-period
//   - par()       : parity of a payload (zero-extended to PAR_MAX_W bits)
package spi_link_pkg;

    localparam int DEF_DATA_W  = 64;
    localparam int DEF_CLK_DIV = 4;

    // Widest payload the parity helper accepts. Narrower payloads are
    // zero-extended by the caller, which leaves the XOR unchanged.
    localparam int PAR_MAX_W   = 256;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        ACK_HI,
        ACK_LO
    } state_t;

    // Even parity when odd=0 (XOR of all bits), odd parity when odd=1.
    function automatic logic par(input logic [PAR_MAX_W-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/spi_sack_sync.sv
// Two-flop synchroniser for the asynchronous SACK handshake input.
//   clk    : system clock
//   rst    : synchronous active-high reset, clears both flops
//   sack   : raw acknowledge from the remote receiver
//   sack_s : synchronised acknowledge, two cycles behind sack
module spi_sack_sync (
    input  logic clk,
    input  logic rst,
    input  logic sack,
    output logic sack_s
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta   <= 1'b0;
            sack_s <= 1'b0;
        end else begin
            meta   <= sack;
            sack_s <= meta;
        end
    end

endmodule

// File: rtl/spi_parity_tx.sv
// Transmit-side SPI master with parity. Each accepted WR word is sent
// MSB-first followed by one parity bit, then the receiver's SACK
// high/low handshake is awaited and DONE or ERR is reported.
//   CLK, RESET : clock and synchronous active-high reset
//   WR, DATA   : single-cycle transmit request and its payload
//   BUSY       : transfer in progress (frame or handshake)
//   DONE, ERR  : one-cycle completion / acknowledge-timeout pulses
//   SS, SCLK,
//   SD         : SPI pins (SS active low, SCLK idle low)
//   SACK       : asynchronous acknowledge from the receiver
module spi_parity_tx
    import spi_link_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int CLK_DIV     = DEF_CLK_DIV,
    parameter int ACK_TIMEOUT = 1024,
    parameter int PARITY_ODD  = 0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              WR,
    input  logic [DATA_W-1:0] DATA,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR,
    output logic              SS,
    output logic              SCLK,
    output logic              SD,
    input  logic              SACK
);

    localparam int SH_W  = DATA_W + 1;
    localparam int BIT_W = $clog2(DATA_W + 2);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

    state_t            state, state_n;
    logic [SH_W-1:0]   shreg, shreg_n;
    logic [BIT_W-1:0]  bit_cnt, bit_cnt_n;
    logic [DIV_W-1:0]  div_cnt, div_cnt_n;
    logic [TMO_W-1:0]  tmo_cnt, tmo_cnt_n;
    logic              phase, phase_n;     // 0: SCLK low half, 1: high half
    logic              busy_n, done_n, err_n;
    logic              sack_s;
    logic              in_frame;

    spi_sack_sync u_sack_sync (
        .clk    (CLK),
        .rst    (RESET),
        .sack   (SACK),
        .sack_s (sack_s)
    );

    assign in_frame = (state == SETUP) || (state == SHIFT);

    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        bit_cnt_n = bit_cnt;
        div_cnt_n = div_cnt;
        tmo_cnt_n = tmo_cnt;
        phase_n   = phase;
        busy_n    = BUSY;
        done_n    = 1'b0;
        err_n     = 1'b0;

        case (state)
            IDLE: begin
                if (WR) begin
                    // Parity rides along as the last bit of the shift register.
                    shreg_n = {DATA, par(PAR_MAX_W'(DATA), 1'(PARITY_ODD))};
                    busy_n  = 1'b1;
                    state_n = SETUP;
                end
            end

            SETUP: begin
                if (div_cnt == DIV_LAST) begin
                    state_n = SHIFT;
                end else begin
                    div_cnt_n = div_cnt + 1'b1;
                end
            end

            SHIFT: begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt_n = '0;
                    if (!phase) begin
                        phase_n = 1'b1;
                    end else if (bit_cnt == BIT_LAST) begin
                        state_n = ACK_HI;
                    end else begin
                        // End of a high half: next bit appears as SCLK falls.
                        phase_n   = 1'b0;
                        bit_cnt_n = bit_cnt + 1'b1;
                        shreg_n   = {shreg[SH_W-2:0], 1'b0};
                    end
                end else begin
                    div_cnt_n = div_cnt + 1'b1;
                end
            end

            ACK_HI: begin
                if (sack_s) begin
                    state_n = ACK_LO;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_n = IDLE;
                    err_n   = 1'b1;
                    busy_n  = 1'b0;
                end else begin
                    tmo_cnt_n = tmo_cnt + 1'b1;
                end
            end

            ACK_LO: begin
                if (!sack_s) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_n = IDLE;
                    err_n   = 1'b1;
                    busy_n  = 1'b0;
                end else begin
                    tmo_cnt_n = tmo_cnt + 1'b1;
                end
            end

            default: state_n = IDLE;
        endcase

        // Every state starts with fresh counters, so none ever wraps.
        if (state_n != state) begin
            div_cnt_n = '0;
            bit_cnt_n = '0;
            tmo_cnt_n = '0;
            phase_n   = 1'b0;
        end
    end

    // The SPI pins are registered copies of the current state, so the
    // pin waveform trails the FSM by one cycle but is glitch free.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
            tmo_cnt <= '0;
            phase   <= 1'b0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            ERR     <= 1'b0;
            SS      <= 1'b1;
            SCLK    <= 1'b0;
            SD      <= 1'b0;
        end else begin
            state   <= state_n;
            shreg   <= shreg_n;
            bit_cnt <= bit_cnt_n;
            div_cnt <= div_cnt_n;
            tmo_cnt <= tmo_cnt_n;
            phase   <= phase_n;
            BUSY    <= busy_n;
            DONE    <= done_n;
            ERR     <= err_n;
            SS      <= !in_frame;
            SCLK    <= (state == SHIFT) && phase;
            SD      <= in_frame && shreg[SH_W-1];
        end
    end

endmodule

// File: tb/tb_spi_parity_tx.sv
// Self-checking bench for spi_parity_tx. Two instances share all inputs:
// dut0 uses even parity, dut1 odd parity. A negedge monitor records the
// bits sampled on each SCLK rising edge and the pin events; each test
// compares them with a frame model built from the payload and popcount.
module tb_spi_parity_tx;

    localparam int DW  = 64;
    localparam int CD  = 2;
    localparam int TMO = 16;
    localparam int FRAME_CYC = CD + (DW + 1) * 2 * CD;

    logic          CLK = 1'b0;
    logic          RESET, WR, SACK;
    logic [DW-1:0] DATA;
    logic          busy0, done0, err0, ss0, sclk0, sd0;
    logic          busy1, done1, err1, ss1, sclk1, sd1;

    always #5 CLK = ~CLK;

    spi_parity_tx #(.DATA_W(DW), .CLK_DIV(CD), .ACK_TIMEOUT(TMO), .PARITY_ODD(0)) dut0 (
        .CLK(CLK), .RESET(RESET), .WR(WR), .DATA(DATA), .BUSY(busy0), .DONE(done0),
        .ERR(err0), .SS(ss0), .SCLK(sclk0), .SD(sd0), .SACK(SACK)
    );

    spi_parity_tx #(.DATA_W(DW), .CLK_DIV(CD), .ACK_TIMEOUT(TMO), .PARITY_ODD(1)) dut1 (
        .CLK(CLK), .RESET(RESET), .WR(WR), .DATA(DATA), .BUSY(busy1), .DONE(done1),
        .ERR(err1), .SS(ss1), .SCLK(sclk1), .SD(sd1), .SACK(SACK)
    );

    int checks = 0;
    int errors = 0;

    // Monitor state
    int cyc = 0;
    int ss_low0, ss_falls, done0_n, err0_n, done1_n, err1_n;
    int ss_fall_cyc, ss_rise_cyc, err_cyc, wr_cyc;
    bit busy_at_done, busy_before_done, busy_at_err, ss_at_err;
    bit ss0_q = 1'b1, sclk0_q = 1'b0, sclk1_q = 1'b0, busy0_q = 1'b0;
    bit q0[$];
    bit q1[$];

    always @(negedge CLK) begin
        cyc++;
        if (ss0 === 1'b0) ss_low0++;
        if (ss0 === 1'b0 && ss0_q) begin ss_fall_cyc = cyc; ss_falls++; end
        if (ss0 === 1'b1 && !ss0_q) ss_rise_cyc = cyc;
        if (sclk0 === 1'b1 && !sclk0_q) q0.push_back(sd0);
        if (sclk1 === 1'b1 && !sclk1_q) q1.push_back(sd1);
        if (done0 === 1'b1) begin
            done0_n++;
            busy_at_done     = busy0;
            busy_before_done = busy0_q;
        end
        if (err0 === 1'b1) begin
            err0_n++;
            err_cyc     = cyc;
            busy_at_err = busy0;
            ss_at_err   = ss0;
        end
        if (done1 === 1'b1) done1_n++;
        if (err1 === 1'b1) err1_n++;
        ss0_q   = (ss0 === 1'b1);
        sclk0_q = (sclk0 === 1'b1);
        sclk1_q = (sclk1 === 1'b1);
        busy0_q = (busy0 === 1'b1);
    end

    // Reference frame: payload MSB-first then parity from the popcount.
    function automatic logic [DW:0] model(input logic [DW-1:0] d, input bit odd);
        bit p;
        p = (($countones(d) % 2) == 1) ^ odd;
        return {d, p};
    endfunction

    // Gathers DW+1 sampled bits starting at off into a word, first bit at MSB.
    function automatic logic [DW:0] pack(input bit q[$], input int off);
        logic [DW:0] v;
        v = '0;
        for (int i = 0; i <= DW; i++)
            if (off + i < q.size()) v[DW-i] = q[off+i];
        return v;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic clear_mon();
        q0.delete();
        q1.delete();
        ss_low0  = 0;
        ss_falls = 0;
        done0_n  = 0;
        err0_n   = 0;
        done1_n  = 0;
        err1_n   = 0;
    endtask

    task automatic send(input logic [DW-1:0] d);
        WR     = 1'b1;
        DATA   = d;
        wr_cyc = cyc + 1;
        tick(1);
        WR     = 1'b0;
    endtask

    task automatic wait_frame(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100 && ss0 !== 1'b0; i++) tick(1);
        if (ss0 === 1'b0) begin
            for (int i = 0; i < 2000 && ss0 !== 1'b1; i++) tick(1);
            ok = (ss0 === 1'b1);
        end
    endtask

    task automatic do_ack();
        tick(10);
        SACK = 1'b1;
        tick(10);
        SACK = 1'b0;
    endtask

    task automatic wait_end(output bit ok);
        for (int i = 0; i < 200 && done0 !== 1'b1 && err0 !== 1'b1; i++) tick(1);
        ok = (done0 === 1'b1) || (err0 === 1'b1);
        tick(1);
    endtask

    task automatic run_frame(input logic [DW-1:0] d, output bit ok);
        bit ok1, ok2;
        send(d);
        wait_frame(ok1);
        do_ack();
        wait_end(ok2);
        ok = ok1 && ok2;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        WR    = 1'b0;
        SACK  = 1'b0;
        DATA  = '0;
        tick(3);
        checks++;
        if ({ss0, sclk0, sd0, busy0, done0, err0} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_pins0 got %b required 100000", {ss0, sclk0, sd0, busy0, done0, err0});
        end
        checks++;
        if ({ss1, sclk1, sd1, busy1, done1, err1} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_pins1 got %b required 100000", {ss1, sclk1, sd1, busy1, done1, err1});
        end
        RESET = 1'b0;
        tick(3);
        checks++;
        if ({ss0, sclk0, sd0, busy0, done0, err0} !== 6'b100000) begin
            errors++;
            $display("FAIL idle_pins got %b required 100000", {ss0, sclk0, sd0, busy0, done0, err0});
        end
    endtask

    task automatic test_single();
        logic [DW-1:0] d;
        bit ok;
        d = 64'h0123456789ABCDEF;
        clear_mon();
        run_frame(d, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL single_timeout got no frame end required DONE"); end
        checks++;
        if (ss_low0 != FRAME_CYC) begin
            errors++;
            $display("FAIL single_ss_low got %0d required %0d", ss_low0, FRAME_CYC);
        end
        checks++;
        if (q0.size() != DW + 1) begin
            errors++;
            $display("FAIL single_edges got %0d required %0d", q0.size(), DW + 1);
        end
        checks++;
        if (pack(q0, 0) !== model(d, 1'b0)) begin
            errors++;
            $display("FAIL single_bits got %h required %h", pack(q0, 0), model(d, 1'b0));
        end
        checks++;
        if (pack(q0, 0) !== {d, 1'b0}) begin
            errors++;
            $display("FAIL single_parity got %h required %h", pack(q0, 0), {d, 1'b0});
        end
        checks++;
        if (done0_n != 1 || err0_n != 0) begin
            errors++;
            $display("FAIL single_done got done=%0d err=%0d required done=1 err=0", done0_n, err0_n);
        end
        checks++;
        if (busy_at_done !== 1'b0 || busy_before_done !== 1'b1) begin
            errors++;
            $display("FAIL single_busy_fall got at=%0b before=%0b required at=0 before=1",
                     busy_at_done, busy_before_done);
        end
        checks++;
        if (ss_fall_cyc - wr_cyc != 2) begin
            errors++;
            $display("FAIL single_ss_latency got %0d required 2", ss_fall_cyc - wr_cyc);
        end
        checks++;
        if (pack(q1, 0) !== model(d, 1'b1) || done1_n != 1) begin
            errors++;
            $display("FAIL single_odd got %h done=%0d required %h done=1", pack(q1, 0), done1_n, model(d, 1'b1));
        end
    endtask

    task automatic test_parity();
        bit ok;
        clear_mon();
        run_frame(64'h1, ok);
        checks++;
        if (!ok || q0.size() != DW + 1 || q0[DW] !== 1'b1) begin
            errors++;
            $display("FAIL parity_even got %0b (edges %0d) required 1", (q0.size() > DW) ? q0[DW] : 1'b0, q0.size());
        end
        checks++;
        if (q1.size() != DW + 1 || q1[DW] !== 1'b0) begin
            errors++;
            $display("FAIL parity_odd got %0b (edges %0d) required 0", (q1.size() > DW) ? q1[DW] : 1'b1, q1.size());
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] d;
        bit ok;
        for (int k = 0; k < 4; k++) begin
            d = {$urandom, $urandom};
            clear_mon();
            run_frame(d, ok);
            checks++;
            if (!ok || pack(q0, 0) !== model(d, 1'b0) || done0_n != 1) begin
                errors++;
                $display("FAIL random_even got %h done=%0d required %h done=1", pack(q0, 0), done0_n, model(d, 1'b0));
            end
            checks++;
            if (pack(q1, 0) !== model(d, 1'b1) || done1_n != 1) begin
                errors++;
                $display("FAIL random_odd got %h done=%0d required %h done=1", pack(q1, 0), done1_n, model(d, 1'b1));
            end
        end
    endtask

    task automatic test_timeout();
        bit ok1, ok2;
        clear_mon();
        SACK = 1'b0;
        send({$urandom, $urandom});
        wait_frame(ok1);
        wait_end(ok2);
        checks++;
        if (!ok1 || !ok2 || err0_n != 1 || done0_n != 0) begin
            errors++;
            $display("FAIL timeout_err got err=%0d done=%0d required err=1 done=0", err0_n, done0_n);
        end
        // ACK_HI is entered the cycle before SS is seen high, so the
        // 16-cycle timeout shows as 15 cycles after the SS rise.
        checks++;
        if (err_cyc - ss_rise_cyc != TMO - 1) begin
            errors++;
            $display("FAIL timeout_delay got %0d required %0d", err_cyc - ss_rise_cyc, TMO - 1);
        end
        checks++;
        if (ss_at_err !== 1'b1 || busy_at_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pins got ss=%0b busy=%0b required ss=1 busy=0", ss_at_err, busy_at_err);
        end
    endtask

    task automatic test_wr_ignored();
        logic [DW-1:0] d;
        bit ok1, ok2;
        d = {$urandom, $urandom};
        clear_mon();
        send(d);
        tick(50);
        WR   = 1'b1;
        DATA = '1;
        tick(1);
        WR   = 1'b0;
        wait_frame(ok1);
        do_ack();
        wait_end(ok2);
        tick(20);
        checks++;
        if (!ok1 || !ok2 || pack(q0, 0) !== model(d, 1'b0) || q0.size() != DW + 1) begin
            errors++;
            $display("FAIL wr_ignored_bits got %h edges=%0d required %h", pack(q0, 0), q0.size(), model(d, 1'b0));
        end
        checks++;
        if (done0_n != 1 || ss_falls != 1 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL wr_ignored_count got done=%0d frames=%0d busy=%0b required 1 1 0", done0_n, ss_falls, busy0);
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] d;
        bit ok;
        clear_mon();
        send({$urandom, $urandom});
        for (int i = 0; i < 1000 && q0.size() < 30; i++) tick(1);
        RESET = 1'b1;
        tick(1);
        checks++;
        if ({ss0, sclk0, busy0} !== 3'b100) begin
            errors++;
            $display("FAIL reset_mid_pins got %b required 100", {ss0, sclk0, busy0});
        end
        RESET = 1'b0;
        tick(40);
        checks++;
        if (done0_n != 0 || err0_n != 0) begin
            errors++;
            $display("FAIL reset_mid_pulses got done=%0d err=%0d required 0 0", done0_n, err0_n);
        end
        d = {$urandom, $urandom};
        clear_mon();
        run_frame(d, ok);
        checks++;
        if (!ok || pack(q0, 0) !== model(d, 1'b0) || q0.size() != DW + 1 || done0_n != 1) begin
            errors++;
            $display("FAIL reset_mid_fresh got %h edges=%0d done=%0d required %h", pack(q0, 0), q0.size(),
                     done0_n, model(d, 1'b0));
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] a, b;
        bit ok1, ok2, ok3;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        clear_mon();
        send(a);
        wait_frame(ok1);
        do_ack();
        for (int i = 0; i < 200 && done0 !== 1'b1; i++) tick(1);
        tick(1);
        send(b);
        wait_frame(ok2);
        checks++;
        if (!ok1 || !ok2 || ss_fall_cyc - wr_cyc != 2) begin
            errors++;
            $display("FAIL b2b_start got %0d required 2", ss_fall_cyc - wr_cyc);
        end
        do_ack();
        wait_end(ok3);
        checks++;
        if (!ok3 || q0.size() != 2 * (DW + 1) || pack(q0, 0) !== model(a, 1'b0)
            || pack(q0, DW + 1) !== model(b, 1'b0)) begin
            errors++;
            $display("FAIL b2b_words got %h %h required %h %h", pack(q0, 0), pack(q0, DW + 1),
                     model(a, 1'b0), model(b, 1'b0));
        end
        checks++;
        if (done0_n != 2 || err0_n != 0) begin
            errors++;
            $display("FAIL b2b_done got done=%0d err=%0d required 2 0", done0_n, err0_n);
        end
    endtask

    initial begin
        RESET = 1'b1;
        WR    = 1'b0;
        SACK  = 1'b0;
        DATA  = '0;
        test_reset();
        test_single();
        test_parity();
        test_random();
        test_timeout();
        test_wr_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
